// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared constants, FSM state type and lane-merge helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam int RDW_NEW = 0;
    localparam int RDW_OLD = 1;

    // Widest word the lane-merge helper handles; callers cast in and out.
    localparam int MERGE_W = 256;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] lane_en,
        input int                 lane_w
    );
        logic [MERGE_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MERGE_W; i++) begin
            if (lane_en[8'(i / lane_w)]) begin
                r[8'(i)] = new_w[8'(i)];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dual_port_mem_ctl_if.sv
// ---------------------------------------------------------------------------
// dual_port_mem_ctl_if : host port A and loader port B bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dual_port_mem_ctl_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 12,
    parameter int BYTEWIDTH = 8
);
    localparam int NLANES = DATAWIDTH / BYTEWIDTH;

    logic [ADDRWIDTH-1:0] a_address;
    logic [DATAWIDTH-1:0] a_data;
    logic                 a_wren;
    logic [NLANES-1:0]    a_byteena;
    logic [DATAWIDTH-1:0] a_q;
    logic                 a_q_valid;

    logic                 b_valid;
    logic                 b_ready;
    logic [ADDRWIDTH-1:0] b_address;
    logic [DATAWIDTH-1:0] b_data;
    logic                 b_wren;
    logic [DATAWIDTH-1:0] b_q;
    logic                 b_q_valid;

    logic                 busy;

    modport master (
        output a_address, a_data, a_wren, a_byteena,
        output b_valid, b_address, b_data, b_wren,
        input  a_q, a_q_valid, b_ready, b_q, b_q_valid, busy
    );

    modport slave (
        input  a_address, a_data, a_wren, a_byteena,
        input  b_valid, b_address, b_data, b_wren,
        output a_q, a_q_valid, b_ready, b_q, b_q_valid, busy
    );

endinterface

`default_nettype wire

// File: rtl/dual_port_mem_ctl_clear_seq.sv
// ---------------------------------------------------------------------------
// mem_clear_seq : post-reset fill sequencer, owns the port-B array mux select
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int ADDRWIDTH      = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic                 clock,
    input  wire logic                 reset_n,
    output logic                      clr_we_o,
    output logic [ADDRWIDTH-1:0]      clr_addr_o,
    output logic                      busy_o,
    output logic                      run_o
);

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
    logic                 run_q, run_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = RUN;
            end
        end
        // Registered so the loader handshake stays low through reset.
        run_d = (state_d == RUN);
    end

    always_comb begin
        clr_we_o   = (state_q == CLEAR);
        clr_addr_o = cnt_q;
        busy_o     = (state_q == CLEAR);
        run_o      = run_q;
    end

endmodule

`default_nettype wire

// File: rtl/dual_port_mem_ctl.sv
// ---------------------------------------------------------------------------
// dual_port_mem_ctl : true dual-port memory with byte enables, RDW select,
// valid/ready loader port and post-reset clear.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dual_port_mem_ctl
    import mem_pkg::*;
#(
    parameter int                  DATAWIDTH      = 8,
    parameter int                  ADDRWIDTH      = 12,
    parameter int                  BYTEWIDTH      = 8,
    parameter int                  RDW_MODE       = 0,
    parameter bit                  CLEAR_ON_RESET = 1'b1,
    parameter logic [DATAWIDTH-1:0] CLEAR_VALUE   = '0,
    parameter                      INITFILE       = " "
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    dual_port_mem_ctl_if.slave bus
);

    localparam int NLANES = DATAWIDTH / BYTEWIDTH;
    localparam int DEPTH  = 2 ** ADDRWIDTH;

    // INITFILE is consumed by the device configuration flow, not by logic.
    if (((DATAWIDTH % BYTEWIDTH) != 0) || ($bits(INITFILE) == 0)) begin : g_bad_cfg
        $error("dual_port_mem_ctl: DATAWIDTH must be a multiple of BYTEWIDTH");
    end

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    logic                 clr_we, run, busy;
    logic [ADDRWIDTH-1:0] clr_addr;

    logic                 a_vld_q, b_vld_q, b_wr_q;
    logic [ADDRWIDTH-1:0] a_addr_q, b_addr_q;
    logic [DATAWIDTH-1:0] a_data_q, b_data_q;
    logic [NLANES-1:0]    a_be_q;
    logic [DATAWIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                 a_rvld_q, b_rvld_q;

    logic [DATAWIDTH-1:0] a_old, b_old, a_merged, pb_data;
    logic [ADDRWIDTH-1:0] pb_addr;
    logic                 a_wr, pb_we, collide;

    mem_clear_seq #(
        .ADDRWIDTH      (ADDRWIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy),
        .run_o      (run)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_vld_q   <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            a_be_q    <= '0;
            b_vld_q   <= 1'b0;
            b_wr_q    <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            a_rdata_q <= '0;
            a_rvld_q  <= 1'b0;
            b_rdata_q <= '0;
            b_rvld_q  <= 1'b0;
        end else begin
            a_vld_q   <= run;
            a_addr_q  <= bus.a_address;
            a_data_q  <= bus.a_data;
            a_be_q    <= bus.a_wren ? bus.a_byteena : '0;
            b_vld_q   <= bus.b_valid & run;
            b_wr_q    <= bus.b_wren;
            b_addr_q  <= bus.b_address;
            b_data_q  <= bus.b_data;
            a_rvld_q  <= a_vld_q;
            b_rvld_q  <= b_vld_q;
            if (a_vld_q) begin
                a_rdata_q <= a_rdata_d;
            end
            if (b_vld_q) begin
                b_rdata_q <= b_rdata_d;
            end
        end
    end

    always_comb begin
        a_old    = mem_q[a_addr_q];
        b_old    = mem_q[b_addr_q];
        a_wr     = a_vld_q && (|a_be_q);
        a_merged = DATAWIDTH'(lane_merge(MERGE_W'(a_old), MERGE_W'(a_data_q),
                                         MERGE_W'(a_be_q), BYTEWIDTH));

        // Port B of the array is owned by the clear sequencer while it runs.
        pb_we    = clr_we ? 1'b1 : (b_vld_q & b_wr_q);
        pb_addr  = clr_we ? clr_addr : b_addr_q;
        pb_data  = clr_we ? CLEAR_VALUE : b_data_q;
        collide  = a_wr && pb_we && (a_addr_q == pb_addr);

        a_rdata_d = a_old;
        if (a_wr && (RDW_MODE == RDW_NEW)) begin
            a_rdata_d = collide ? pb_data : a_merged;
        end

        b_rdata_d = b_old;
        if (b_vld_q && b_wr_q && (RDW_MODE == RDW_NEW)) begin
            b_rdata_d = b_data_q;
        end
    end

    // Port B wins a same-address double write.
    always_ff @(posedge clock) begin
        if (a_wr && !collide) begin
            mem_q[a_addr_q] <= a_merged;
        end
        if (pb_we) begin
            mem_q[pb_addr] <= pb_data;
        end
    end

    assign bus.a_q       = a_rdata_q;
    assign bus.a_q_valid = a_rvld_q;
    assign bus.b_q       = b_rdata_q;
    assign bus.b_q_valid = b_rvld_q;
    assign bus.b_ready   = run;
    assign bus.busy      = busy;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_mem_ctl.sv
// ---------------------------------------------------------------------------
// tb_dual_port_mem_ctl : directed bench, three DUTs (8b new, 8b old, 16b new)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dual_port_mem_ctl;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  a_addr;
    logic [15:0] a_dat;
    logic        a_wr;
    logic [1:0]  a_be;
    logic        b_val;
    logic [3:0]  b_addr;
    logic [15:0] b_dat;
    logic        b_wr;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          bad;
    int          cyc;

    always #5 clock = ~clock;

    dual_port_mem_ctl_if #(.DATAWIDTH(8),  .ADDRWIDTH(4), .BYTEWIDTH(8)) if0 ();
    dual_port_mem_ctl_if #(.DATAWIDTH(8),  .ADDRWIDTH(4), .BYTEWIDTH(8)) if1 ();
    dual_port_mem_ctl_if #(.DATAWIDTH(16), .ADDRWIDTH(4), .BYTEWIDTH(8)) if2 ();

    assign if0.a_address = a_addr;   assign if1.a_address = a_addr;   assign if2.a_address = a_addr;
    assign if0.a_data    = a_dat[7:0]; assign if1.a_data  = a_dat[7:0]; assign if2.a_data    = a_dat;
    assign if0.a_wren    = a_wr;     assign if1.a_wren    = a_wr;     assign if2.a_wren    = a_wr;
    assign if0.a_byteena = a_be[0:0]; assign if1.a_byteena = a_be[0:0]; assign if2.a_byteena = a_be;
    assign if0.b_valid   = b_val;    assign if1.b_valid   = b_val;    assign if2.b_valid   = b_val;
    assign if0.b_address = b_addr;   assign if1.b_address = b_addr;   assign if2.b_address = b_addr;
    assign if0.b_data    = b_dat[7:0]; assign if1.b_data  = b_dat[7:0]; assign if2.b_data    = b_dat;
    assign if0.b_wren    = b_wr;     assign if1.b_wren    = b_wr;     assign if2.b_wren    = b_wr;

    dual_port_mem_ctl #(.DATAWIDTH(8), .ADDRWIDTH(4), .BYTEWIDTH(8), .RDW_MODE(0),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5), .INITFILE(" "))
        dut0 (.clock(clock), .reset_n(reset_n), .bus(if0.slave));
    dual_port_mem_ctl #(.DATAWIDTH(8), .ADDRWIDTH(4), .BYTEWIDTH(8), .RDW_MODE(1),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5), .INITFILE(" "))
        dut1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));
    dual_port_mem_ctl #(.DATAWIDTH(16), .ADDRWIDTH(4), .BYTEWIDTH(8), .RDW_MODE(0),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h00A5), .INITFILE(" "))
        dut2 (.clock(clock), .reset_n(reset_n), .bus(if2.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_addr = '0; a_dat = '0; a_wr = 1'b0; a_be = 2'b11;
        // Loader holds a write request from the very start.
        b_val = 1'b1; b_addr = 4'd9; b_dat = 16'hC35A; b_wr = 1'b1;
        repeat (3) @(negedge clock);

        chk("rst_a_q",       16'(if0.a_q), 16'h0000);
        chk("rst_b_q",       if2.b_q, 16'h0000);
        chk("rst_a_q_valid", 16'(if0.a_q_valid), 16'd0);
        chk("rst_b_q_valid", 16'(if1.b_q_valid), 16'd0);
        chk("rst_b_ready",   16'(if0.b_ready), 16'd0);
        chk("rst_busy",      16'(if2.busy), 16'd1);

        // Partial clear, then reset at clear cycle 8.
        reset_n = 1'b1;
        bad = 0;
        repeat (8) begin
            if (!if0.busy || if0.b_ready || if0.b_q_valid) bad++;
            @(negedge clock);
        end
        chk("clear_first8", 16'(bad), 16'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",    16'(if0.busy), 16'd1);
        chk("midrst_b_ready", 16'(if0.b_ready), 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

        cyc = 0; bad = 0;
        while (if0.busy && cyc < 100) begin
            if (if0.b_ready || if0.b_q_valid || if0.a_q_valid || !if2.busy) bad++;
            cyc++;
            @(negedge clock);
        end
        chk("busy_cycles",     16'(cyc), 16'd16);
        chk("clear_quiet",     16'(bad), 16'd0);
        chk("run_b_ready",     16'(if0.b_ready), 16'd1);
        chk("run_busy_16b",    16'(if2.busy), 16'd0);
        chk("run_a_q_valid0",  16'(if0.a_q_valid), 16'd0);

        @(negedge clock);
        b_val = 1'b0;
        chk("ld_b_q_valid_early", 16'(if0.b_q_valid), 16'd0);
        chk("ld_a_q_valid_early", 16'(if0.a_q_valid), 16'd0);
        @(negedge clock);
        chk("ld_b_q_valid", 16'(if0.b_q_valid), 16'd1);
        chk("ld_b_q_new",   16'(if0.b_q), 16'h005A);
        chk("ld_b_q_old",   16'(if1.b_q), 16'h00A5);
        chk("ld_b_q_16b",   if2.b_q, 16'hC35A);
        chk("a_q_valid_2cyc", 16'(if0.a_q_valid), 16'd1);

        // Read sweep of the whole array, one issue per cycle.
        for (int i = 0; i < 18; i++) begin
            if (i >= 2) begin
                chk("sweep_8b_new", 16'(if0.a_q), (i - 2 == 9) ? 16'h005A : 16'h00A5);
                chk("sweep_8b_old", 16'(if1.a_q), (i - 2 == 9) ? 16'h005A : 16'h00A5);
                chk("sweep_16b",    if2.a_q,      (i - 2 == 9) ? 16'hC35A : 16'h00A5);
                chk("sweep_valid",  16'(if0.a_q_valid), 16'd1);
            end
            if (i < 16) a_addr = 4'(i);
            @(negedge clock);
        end

        // Byte enables.
        a_addr = 4'd3; a_dat = 16'h1234; a_wr = 1'b1; a_be = 2'b11;
        @(negedge clock);
        a_dat = 16'hABCD; a_be = 2'b10;
        @(negedge clock);
        chk("be_w1_8b_new", 16'(if0.a_q), 16'h0034);
        chk("be_w1_8b_old", 16'(if1.a_q), 16'h00A5);
        chk("be_w1_16b",    if2.a_q, 16'h1234);
        a_wr = 1'b0;
        @(negedge clock);
        chk("be_w2_8b_new", 16'(if0.a_q), 16'h0034);
        chk("be_w2_8b_old", 16'(if1.a_q), 16'h0034);
        chk("be_w2_16b",    if2.a_q, 16'hAB34);
        @(negedge clock);
        chk("be_rd_16b",    if2.a_q, 16'hAB34);
        chk("be_rd_8b",     16'(if0.a_q), 16'h0034);

        // Read-during-write on port A.
        a_addr = 4'd5; a_dat = 16'h0011; a_wr = 1'b1; a_be = 2'b11;
        @(negedge clock);
        a_dat = 16'h0022;
        @(negedge clock);
        chk("rdw_w11_new", 16'(if0.a_q), 16'h0011);
        chk("rdw_w11_old", 16'(if1.a_q), 16'h00A5);
        chk("rdw_w11_16b", if2.a_q, 16'h0011);
        a_wr = 1'b0;
        @(negedge clock);
        chk("rdw_w22_new", 16'(if0.a_q), 16'h0022);
        chk("rdw_w22_old", 16'(if1.a_q), 16'h0011);
        chk("rdw_w22_16b", if2.a_q, 16'h0022);
        @(negedge clock);
        chk("rdw_rd_new",  16'(if0.a_q), 16'h0022);
        chk("rdw_rd_old",  16'(if1.a_q), 16'h0022);
        chk("rdw_rd_16b",  if2.a_q, 16'h0022);

        // Cross-port collisions on address 7.
        a_addr = 4'd7; a_dat = 16'h0033; a_wr = 1'b1; a_be = 2'b11;
        b_val = 1'b1; b_addr = 4'd7; b_dat = 16'h0044; b_wr = 1'b1;
        @(negedge clock);
        a_wr = 1'b0; b_dat = 16'h0055;
        @(negedge clock);
        chk("col_ww_a_new", 16'(if0.a_q), 16'h0044);
        chk("col_ww_a_old", 16'(if1.a_q), 16'h00A5);
        chk("col_ww_a_16b", if2.a_q, 16'h0044);
        chk("col_ww_b_new", 16'(if0.b_q), 16'h0044);
        chk("col_ww_b_old", 16'(if1.b_q), 16'h00A5);
        chk("col_ww_b_vld", 16'(if0.b_q_valid), 16'd1);
        b_val = 1'b0;
        @(negedge clock);
        chk("col_rw_a_new", 16'(if0.a_q), 16'h0044);
        chk("col_rw_a_old", 16'(if1.a_q), 16'h0044);
        chk("col_rw_a_16b", if2.a_q, 16'h0044);
        chk("col_rw_b_new", 16'(if0.b_q), 16'h0055);
        chk("col_rw_b_old", 16'(if1.b_q), 16'h0044);
        @(negedge clock);
        chk("col_after_new", 16'(if0.a_q), 16'h0055);
        chk("col_after_old", 16'(if1.a_q), 16'h0055);
        chk("col_b_vld_end", 16'(if0.b_q_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
